// File: rtl/yutorina_gpr_pkg.sv
// Shared constants for the Yutorina general-purpose register file:
// word/address widths, active-low strobe encodings, reset level and
// the sweep FSM state encodings.
package yutorina_gpr_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  // register_write_enable_ is active low
  localparam logic ENABLE_LOW  = 1'b0;
  localparam logic DISABLE_LOW = 1'b1;

  // Reset is asserted low and acts on its falling edge
  localparam logic RESET_ENABLE       = 1'b0;
  localparam logic RESET_EDGE_FALLING = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/yutorina_gpr_bank.sv
// Pure storage array: one write port, two synchronous read ports, no bypass
// and no reset so it can map onto a dual-read RAM or a flop array.
// Ports: clock; we/waddr/wdata write port; raddr0/raddr1 read addresses;
//        rdata0/rdata1 registered read data (old contents on a same-edge write).
module yutorina_gpr_bank
  import yutorina_gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-before-write storage
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

endmodule

// File: rtl/yutorina_gpr.sv
// Yutorina CPU general-purpose register file.
// After reset a sweep sequencer zeroes every register (busy high), then
// the file serves two 1-cycle-latency read ports and one write port with
// write-through bypass and a hardwired-zero register 0.
// Ports: clock, reset (async, active low); register_write_enable_ (active low),
//        write_address, write_data; read_address0/1 -> read_data0/1; busy.
module yutorina_gpr
  import yutorina_gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  register_write_enable_,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address0,
  input  logic [ADDR_WIDTH-1:0] read_address1,
  output logic [DATA_WIDTH-1:0] read_data0,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  gpr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  zero0_q, zero0_d, zero1_q, zero1_d;
  logic                  byp0_q, byp0_d, byp1_q, byp1_d;
  logic [DATA_WIDTH-1:0] byp_word_q;

  logic                  write_hit;
  logic                  bank_we;
  logic [ADDR_WIDTH-1:0] bank_waddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata0, bank_rdata1;

  // State, sweep counter and read-select flags
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q    <= CLEAR;
      count_q    <= '0;
      busy_q     <= 1'b1;
      zero0_q    <= 1'b1;
      zero1_q    <= 1'b1;
      byp0_q     <= 1'b0;
      byp1_q     <= 1'b0;
      byp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      zero0_q    <= zero0_d;
      zero1_q    <= zero1_d;
      byp0_q     <= byp0_d;
      byp1_q     <= byp1_d;
      byp_word_q <= write_data;
    end
  end

  // Sweep FSM, write mux (sweep vs write-back), zero masking, bypass compare
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    write_hit  = 1'b0;
    bank_we    = 1'b0;
    bank_waddr = write_address;
    bank_wdata = write_data;
    zero0_d    = 1'b1;
    zero1_d    = 1'b1;
    byp0_d     = 1'b0;
    byp1_d     = 1'b0;

    case (state_q)
      CLEAR: begin
        bank_we    = 1'b1;
        bank_waddr = count_q;
        bank_wdata = '0;
        // Counter saturates on the last address; that edge enters READY
        if (count_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          count_d = count_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        // An X/Z strobe fails the equality test and is treated as no write
        if ((register_write_enable_ == ENABLE_LOW) && (write_address != '0)) begin
          write_hit = 1'b1;
        end
        bank_we = write_hit;
        zero0_d = (read_address0 == '0);
        zero1_d = (read_address1 == '0);
        byp0_d  = write_hit && (read_address0 == write_address);
        byp1_d  = write_hit && (read_address1 == write_address);
      end
      default: begin
        state_d = CLEAR;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == CLEAR);
  end

  yutorina_gpr_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clock  (clock),
    .we     (bank_we),
    .waddr  (bank_waddr),
    .wdata  (bank_wdata),
    .raddr0 (read_address0),
    .raddr1 (read_address1),
    .rdata0 (bank_rdata0),
    .rdata1 (bank_rdata1)
  );

  // Outputs depend only on flops: zero mask wins over bypass, bypass over bank
  assign read_data0 = zero0_q ? '0 : (byp0_q ? byp_word_q : bank_rdata0);
  assign read_data1 = zero1_q ? '0 : (byp1_q ? byp_word_q : bank_rdata1);
  assign busy       = busy_q;

endmodule
